// File: rtl/thermal_monitor.sv
// rtl/thermal_monitor.sv - multi-sensor thermal supervisor with filtered max tracking and hysteresis FSM
//
// Periodically scans NUM_SENSORS temperature inputs (one per cycle), keeps a
// per-sensor averaging filter and fault counter, then in a single EVAL cycle
// publishes the hottest qualifying sensor and steps the thermal state.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   enable                  interval counter enable
//   sensor_temp/valid       packed per-sensor readings (sensor i at [8i+7:8i])
//   warn/hot/crit_thresh    thresholds in degrees C, sampled in EVAL only
//   irq_clear               clears the sticky irq
//   thermal_state           0 NORMAL, 1 WARM, 2 HOT, 3 CRITICAL
//   throttle_req            state >= HOT
//   shutdown_req            state == CRITICAL
//   max_temp/max_sensor_id  hottest filtered qualifying sensor of last scan
//   sensor_fault            per-sensor fault flags
//   scan_done               one-cycle pulse when results are published
//   irq                     sticky interrupt

module thermal_monitor #(
    parameter int NUM_SENSORS     = 4,
    parameter int SAMPLE_INTERVAL = 256,
    parameter int FAULT_LIMIT     = 3,
    parameter int HYST            = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic [8*NUM_SENSORS-1:0]       sensor_temp,
    input  logic [NUM_SENSORS-1:0]         sensor_valid,
    input  logic [7:0]                     warn_thresh,
    input  logic [7:0]                     hot_thresh,
    input  logic [7:0]                     crit_thresh,
    input  logic                           irq_clear,
    output logic [1:0]                     thermal_state,
    output logic                           throttle_req,
    output logic                           shutdown_req,
    output logic [7:0]                     max_temp,
    output logic [$clog2(NUM_SENSORS)-1:0] max_sensor_id,
    output logic [NUM_SENSORS-1:0]         sensor_fault,
    output logic                           scan_done,
    output logic                           irq
);

    localparam int              IDW      = $clog2(NUM_SENSORS);
    localparam int              CW       = $clog2(SAMPLE_INTERVAL);
    localparam logic [CW-1:0]   CNT_LAST = CW'(SAMPLE_INTERVAL - 1);
    localparam logic [IDW-1:0]  IDX_LAST = IDW'(NUM_SENSORS - 1);
    localparam logic [3:0]      FLIM     = 4'(FAULT_LIMIT);
    localparam logic [8:0]      HYST9    = 9'(HYST);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EVAL = 2'd2
    } fsm_t;

    fsm_t                   r_fsm;
    logic [IDW-1:0]         r_idx;
    logic [CW-1:0]          r_cnt;

    logic [7:0]             r_filt   [NUM_SENSORS];
    logic [3:0]             r_fcnt   [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] r_loaded;
    logic [NUM_SENSORS-1:0] r_fault;

    logic [1:0]             r_state;
    logic                   r_throttle;
    logic                   r_shutdown;
    logic [7:0]             r_max_temp;
    logic [IDW-1:0]         r_max_id;
    logic [NUM_SENSORS-1:0] r_sensor_fault;
    logic                   r_scan_done;
    logic                   r_irq;

    logic                   w_start;
    logic [8:0]             w_sum    [NUM_SENSORS];
    logic [7:0]             w_max_temp;
    logic [IDW-1:0]         w_max_id;
    logic                   w_found;
    logic [1:0]             w_level;
    logic [7:0]             w_thr_cur;
    logic [1:0]             w_next_state;
    logic                   w_irq_set;

    assign w_start = enable && (r_cnt == CNT_LAST) && (r_fsm == ST_IDLE);

    // Interval counter: free-runs while enabled, parked at 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!enable || r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= ST_IDLE;
            r_idx <= '0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (w_start) begin
                        r_fsm <= ST_SCAN;
                        r_idx <= '0;
                    end
                end
                ST_SCAN: begin
                    if (r_idx == IDX_LAST) begin
                        r_fsm <= ST_EVAL;
                    end else begin
                        r_idx <= r_idx + IDW'(1);
                    end
                end
                ST_EVAL: r_fsm <= ST_IDLE;
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end

    // 9-bit sum keeps the carry so the halving average cannot wrap.
    always_comb begin
        for (int i = 0; i < NUM_SENSORS; i++) begin
            w_sum[i] = {1'b0, r_filt[i]} + {1'b0, sensor_temp[8*i +: 8]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loaded <= '0;
            r_fault  <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                r_filt[i] <= '0;
                r_fcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (r_fsm == ST_SCAN && r_idx == IDW'(i)) begin
                    if (sensor_valid[i]) begin
                        r_filt[i]   <= r_loaded[i] ? w_sum[i][8:1] : sensor_temp[8*i +: 8];
                        r_loaded[i] <= 1'b1;
                        r_fcnt[i]   <= '0;
                        r_fault[i]  <= 1'b0;
                    end else if (r_fcnt[i] != FLIM) begin
                        r_fcnt[i] <= r_fcnt[i] + 4'd1;
                        if (r_fcnt[i] + 4'd1 == FLIM) begin
                            r_fault[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Hottest non-faulted, ever-valid sensor; strict compare keeps the lowest index on ties.
    always_comb begin
        w_max_temp = '0;
        w_max_id   = '0;
        w_found    = 1'b0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (r_loaded[i] && !r_fault[i] && (!w_found || r_filt[i] > w_max_temp)) begin
                w_max_temp = r_filt[i];
                w_max_id   = IDW'(i);
                w_found    = 1'b1;
            end
        end
    end

    // Crit is tested first so misordered thresholds resolve to the higher level.
    always_comb begin
        w_level = 2'd0;
        if (w_max_temp >= crit_thresh) begin
            w_level = 2'd3;
        end else if (w_max_temp >= hot_thresh) begin
            w_level = 2'd2;
        end else if (w_max_temp >= warn_thresh) begin
            w_level = 2'd1;
        end
    end

    always_comb begin
        case (r_state)
            2'd1:    w_thr_cur = warn_thresh;
            2'd2:    w_thr_cur = hot_thresh;
            2'd3:    w_thr_cur = crit_thresh;
            default: w_thr_cur = 8'd0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        if (&r_fault) begin
            w_next_state = 2'd3;
        end else if (w_level > r_state) begin
            w_next_state = w_level;
        end else if (w_level < r_state && ({1'b0, w_max_temp} + HYST9) < {1'b0, w_thr_cur}) begin
            w_next_state = r_state - 2'd1;
        end
    end

    assign w_irq_set = (r_fsm == ST_EVAL) &&
                       ((w_next_state > r_state) || (|(r_fault & ~r_sensor_fault)));

    // All status outputs are published together in the EVAL cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= 2'd0;
            r_throttle     <= 1'b0;
            r_shutdown     <= 1'b0;
            r_max_temp     <= '0;
            r_max_id       <= '0;
            r_sensor_fault <= '0;
            r_scan_done    <= 1'b0;
            r_irq          <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            r_irq       <= w_irq_set | (r_irq & ~irq_clear);
            if (r_fsm == ST_EVAL) begin
                r_state        <= w_next_state;
                r_throttle     <= (w_next_state >= 2'd2);
                r_shutdown     <= (w_next_state == 2'd3);
                r_max_temp     <= w_max_temp;
                r_max_id       <= w_max_id;
                r_sensor_fault <= r_fault;
                r_scan_done    <= 1'b1;
            end
        end
    end

    assign thermal_state = r_state;
    assign throttle_req  = r_throttle;
    assign shutdown_req  = r_shutdown;
    assign max_temp      = r_max_temp;
    assign max_sensor_id = r_max_id;
    assign sensor_fault  = r_sensor_fault;
    assign scan_done     = r_scan_done;
    assign irq           = r_irq;

endmodule
